// File: rtl/shift_term_encoder_if.sv
// Handshake and result bundle for shift_term_encoder: weight in, signed shift terms out.
// The master side drives the weight and accepts the result; the slave side is the encoder.
interface shift_term_encoder_if #(
    parameter int BITS  = 17,
    parameter int DEPTH = 3
) ();
    localparam int SW = $clog2(BITS + 2) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [BITS-1:0]       weight;
    logic                  out_valid;
    logic                  out_ready;
    logic [DEPTH*SW-1:0]   shift_terms;
    logic [BITS+1:0]       remainder;
    logic                  exact;

    modport master (
        output in_valid, weight, out_ready,
        input  in_ready, out_valid, shift_terms, remainder, exact
    );

    modport slave (
        input  in_valid, weight, out_ready,
        output in_ready, out_valid, shift_terms, remainder, exact
    );
endinterface

// File: rtl/shift_term_encoder.sv
// Greedy nearest-power-of-two encoder: expresses a signed constant as DEPTH signed
// shift terms (+/-(n+1) meaning +/-2^n), one term per cycle, plus the residue left over.
module shift_term_encoder #(
    parameter int BITS  = 17,
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    shift_term_encoder_if.slave  bus
);
    localparam int SW = $clog2(BITS + 2) + 1;
    localparam int RW = BITS + 2;
    localparam int IW = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic signed [RW-1:0]  r_q, r_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DEPTH*SW-1:0]   terms_q, terms_d;
    logic                  exact_q, exact_d;

    logic [RW-1:0]         mag;
    logic [SW-1:0]         msb;
    logic                  half;
    logic [SW-1:0]         n_sel;
    logic signed [RW-1:0]  step;
    logic signed [SW-1:0]  mag_term;
    logic signed [SW-1:0]  term;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        mag  = r_q[RW-1] ? -r_q : r_q;
        msb  = '0;
        half = 1'b0;
        for (int i = 1; i <= BITS; i++) begin
            if (mag[i]) begin
                msb  = SW'(i);
                half = mag[i-1];
            end
        end
        // Bit below the MSB set means |r| >= 1.5*2^msb: the next power is at least as close (ties go up).
        n_sel    = (half && (msb < SW'(BITS))) ? msb + SW'(1) : msb;
        step     = RW'(1) << n_sel;
        mag_term = $signed(n_sel + SW'(1));
        term     = r_q[RW-1] ? -mag_term : mag_term;
    end

    // NOTE: next-state logic uses blocking assignments; only the always_ff below uses <=.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        terms_d = terms_q;
        exact_d = exact_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d     = RW'($signed(bus.weight));
                    idx_d   = '0;
                    terms_d = '0;
                    exact_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (idx_q == IW'(DEPTH)) begin
                    exact_d = (r_q == '0);
                    state_d = DONE;
                end else begin
                    if (r_q != '0) begin
                        terms_d[idx_q*SW +: SW] = term;
                        r_d = r_q[RW-1] ? r_q + step : r_q - step;
                    end
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the term register is reset too, because its contents are visible outputs that must read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            idx_q   <= '0;
            terms_q <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            terms_q <= terms_d;
            exact_q <= exact_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.shift_terms = terms_q;
    assign bus.remainder   = r_q;
    assign bus.exact       = exact_q;
endmodule

// File: doc/shift_term_encoder.md
SHIFT_TERM_ENCODER -- requirements
Module: shift_term_encoder

Interface
REQ-001 SHALL have parameter BITS, default 17, width of the signed input weight.
REQ-002 SHALL have parameter DEPTH, default 3, number of shift terms produced per weight.
REQ-003 SHALL define localparam SW = $clog2(BITS+2)+1, the signed width of one shift term.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, weight present.
REQ-007 SHALL have port in_ready, output, 1, encoder can accept a weight.
REQ-008 SHALL have port weight, input, BITS, two's-complement constant to encode.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port shift_terms, output, DEPTH*SW, signed terms; term i (1..DEPTH) at bits [i*SW-1 -: SW].
REQ-012 SHALL have port remainder, output, BITS+2, signed residue left after DEPTH terms.
REQ-013 SHALL have port exact, output, 1, high when remainder == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: in_ready = 1; on in_valid && in_ready, SHALL latch sign-extended weight into residue r (BITS+2 bits), clear term index, clear all shift_terms, and go to CALC.
REQ-016 CALC: in_ready = 0, out_valid = 0; SHALL produce exactly one term per cycle, for DEPTH cycles, then go to DONE.
REQ-017 Per CALC cycle, if r != 0, SHALL select n in [0, BITS] minimising ||r| - 2^n|; on a tie, SHALL select the larger n.
REQ-018 SHALL write term = +(n+1) if r > 0, -(n+1) if r < 0, and SHALL update r = r - 2^n (r > 0) or r + 2^n (r < 0).
REQ-019 If r == 0, SHALL write term = 0 and leave r unchanged; CALC still lasts exactly DEPTH cycles (fixed latency).
REQ-020 Arithmetic SHALL be in BITS+2 signed bits so that |-2^(BITS-1)| and 2^BITS never overflow.
REQ-021 DONE: out_valid = 1; shift_terms, remainder and exact SHALL hold stable until out_valid && out_ready, then the FSM SHALL return to IDLE.
REQ-022 in_ready SHALL be 0 in CALC and DONE; a new weight is accepted no earlier than the cycle after the output handshake.
REQ-023 Latency: for an input handshake at edge k, out_valid SHALL rise at edge k+DEPTH+1 (one entry edge plus DEPTH CALC cycles).
REQ-024 in_valid or weight changes during CALC or DONE SHALL be ignored.
REQ-025 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, in_ready = 1, out_valid = 0, shift_terms = 0, remainder = 0, exact = 0, regardless of current state.
REQ-027 Reset asserted mid-CALC or in DONE SHALL discard the result in progress; no out_valid pulse SHALL follow reset release.
REQ-028 The first input handshake SHALL be possible on the first rising edge after reset_n goes high.

Verification
REQ-029 weight = 5, BITS=17, DEPTH=3 -> terms {+3,+1,0}, remainder 0, exact 1, out_valid at handshake edge + 4.
REQ-030 weight = -5 -> {-3,-1,0}, exact 1; weight = 7 -> {+4,-1,0}, exact 1; weight = 3 (tie case) -> {+3,-1,0}.
REQ-031 weight = 85 -> {+7,+5,+3}, remainder 1, exact 0; weight = 0 -> {0,0,0}, remainder 0, exact 1.
REQ-032 weight = -65536 (most negative 17-bit value) -> {-17,0,0}, remainder 0, exact 1, with no overflow.
REQ-033 out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next edge, and the next weight is accepted.
REQ-034 reset_n pulsed low during the 2nd CALC cycle -> all outputs 0 immediately, no out_valid afterwards, and a fresh weight = 11 -> {+4,+3,-1}, exact 1.
